// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with the RISC-V debug transport
// registers (IDCODE, DTMCS, DMI, BYPASS).
`default_nettype none

module jtag_tap_ctrl #(
  parameter int DMI_ADDR_BITS = 7,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int DMI_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter int IR_BITS       = 5
) (
  input  logic                jtag_tck_i,
  input  logic                jtag_trst_ni,
  input  logic                jtag_tms_i,
  input  logic                jtag_tdi_i,
  output logic                jtag_tdo_o,
  output logic                jtag_tdo_oe_o,
  output logic                tap_req_o,
  output logic [DMI_BITS-1:0] tap_data_o,
  output logic                dmireset_o,
  input  logic [DMI_BITS-1:0] dtm_data_i,
  input  logic [31:0]         idcode_i,
  input  logic [31:0]         dtmcs_i
);

  localparam int DR_W = (DMI_BITS > 32) ? DMI_BITS : 32;

  localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(5'h01);
  localparam logic [IR_BITS-1:0] IR_DTMCS  = IR_BITS'(5'h10);
  localparam logic [IR_BITS-1:0] IR_DMI    = IR_BITS'(5'h11);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] SELECT_DR        = 4'd2;
  localparam logic [3:0] CAPTURE_DR       = 4'd3;
  localparam logic [3:0] SHIFT_DR         = 4'd4;
  localparam logic [3:0] EXIT1_DR         = 4'd5;
  localparam logic [3:0] PAUSE_DR         = 4'd6;
  localparam logic [3:0] EXIT2_DR         = 4'd7;
  localparam logic [3:0] UPDATE_DR        = 4'd8;
  localparam logic [3:0] SELECT_IR        = 4'd9;
  localparam logic [3:0] CAPTURE_IR       = 4'd10;
  localparam logic [3:0] SHIFT_IR         = 4'd11;
  localparam logic [3:0] EXIT1_IR         = 4'd12;
  localparam logic [3:0] PAUSE_IR         = 4'd13;
  localparam logic [3:0] EXIT2_IR         = 4'd14;
  localparam logic [3:0] UPDATE_IR        = 4'd15;

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [3:0]         state, state_nxt;
  logic [IR_BITS-1:0] ir, ir_sr;
  logic [DR_W-1:0]    dr, dr_cap, dr_sh;
  logic               shift_dr, shift_ir, capture_dr, capture_ir, update_ir;
  logic               sel_idcode, sel_dtmcs, sel_dmi;

  // trst asserts asynchronously but is only released on a TCK edge
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) rst_sync <= 2'b00;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) state <= TEST_LOGIC_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TEST_LOGIC_RESET: state_nxt = jtag_tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = jtag_tms_i ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_nxt = jtag_tms_i ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = jtag_tms_i ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         state_nxt = jtag_tms_i ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         state_nxt = jtag_tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_nxt = jtag_tms_i ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         state_nxt = jtag_tms_i ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_nxt = jtag_tms_i ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_nxt = jtag_tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = jtag_tms_i ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         state_nxt = jtag_tms_i ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         state_nxt = jtag_tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_nxt = jtag_tms_i ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         state_nxt = jtag_tms_i ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_nxt = jtag_tms_i ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    shift_dr   = (state == SHIFT_DR);
    shift_ir   = (state == SHIFT_IR);
    capture_dr = (state == CAPTURE_DR);
    capture_ir = (state == CAPTURE_IR);
    update_ir  = (state == UPDATE_IR);
    tap_req_o  = (state == UPDATE_DR) && sel_dmi;
    dmireset_o = (state == UPDATE_DR) && sel_dtmcs && dr[16];
  end

  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_dtmcs  = (ir == IR_DTMCS);
  assign sel_dmi    = (ir == IR_DMI);

  // Unrecognised instructions fall through to the 1-bit BYPASS register
  always_comb begin
    dr_cap = '0;
    dr_sh  = dr >> 1;
    if (sel_idcode) begin
      dr_cap[31:0] = idcode_i;
      dr_sh[31]    = jtag_tdi_i;
    end else if (sel_dtmcs) begin
      dr_cap[31:0] = dtmcs_i;
      dr_sh[31]    = jtag_tdi_i;
    end else if (sel_dmi) begin
      dr_cap[DMI_BITS-1:0] = dtm_data_i;
      dr_sh[DMI_BITS-1]    = jtag_tdi_i;
    end else begin
      dr_sh[0] = jtag_tdi_i;
    end
  end

  always_ff @(posedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
      dr    <= '0;
    end else begin
      if (state == TEST_LOGIC_RESET) ir <= IR_IDCODE;
      else if (update_ir)            ir <= ir_sr;

      if (capture_ir)    ir_sr <= IR_BITS'(1);
      else if (shift_ir) ir_sr <= {jtag_tdi_i, ir_sr[IR_BITS-1:1]};

      if (capture_dr)    dr <= dr_cap;
      else if (shift_dr) dr <= dr_sh;
    end
  end

  assign tap_data_o = dr[DMI_BITS-1:0];

  always_ff @(negedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else begin
      jtag_tdo_oe_o <= shift_dr | shift_ir;
      jtag_tdo_o    <= shift_dr ? dr[0] : (shift_ir ? ir_sr[0] : 1'b0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed JTAG scans against jtag_tap_ctrl with
// hand-computed expected words.
`default_nettype none

module tb_jtag_tap_ctrl;

  localparam int DMI_BITS = 41;

  logic                tck = 1'b0;
  logic                trst_n, tms, tdi;
  logic                tdo, tdo_oe, tap_req, dmireset;
  logic [DMI_BITS-1:0] tap_data, dtm_data;
  logic [31:0]         idcode, dtmcs;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int rst_cnt = 0;

  jtag_tap_ctrl dut (
    .jtag_tck_i   (tck),
    .jtag_trst_ni (trst_n),
    .jtag_tms_i   (tms),
    .jtag_tdi_i   (tdi),
    .jtag_tdo_o   (tdo),
    .jtag_tdo_oe_o(tdo_oe),
    .tap_req_o    (tap_req),
    .tap_data_o   (tap_data),
    .dmireset_o   (dmireset),
    .dtm_data_i   (dtm_data),
    .idcode_i     (idcode),
    .dtmcs_i      (dtmcs)
  );

  always #10 tck = ~tck;

  // Count strobe cycles as the DTM would see them on the next rising edge
  always @(posedge tck) begin
    if (tap_req)  req_cnt = req_cnt + 1;
    if (dmireset) rst_cnt = rst_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t);
    tms = t;
    tdi = 1'b0;
    @(posedge tck);
    #1;
  endtask

  // Shift n bits LSB first; TDO is sampled after the falling edge that presents it
  task automatic shift(input int n, input logic [63:0] din, input bit do_exit,
                       output logic [63:0] dout, output logic oe_ok);
    dout  = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tms = do_exit && (i == n - 1);
      tdi = din[i];
      @(negedge tck);
      #1;
      dout[i] = tdo;
      if (tdo_oe !== 1'b1) oe_ok = 1'b0;
      @(posedge tck);
      #1;
    end
  endtask

  task automatic ir_scan(input logic [4:0] code, output logic [63:0] cap);
    logic ok;
    step(1); step(1); step(0); step(0);
    shift(5, {59'd0, code}, 1'b1, cap, ok);
    step(1);
    step(0);
  endtask

  // From Run-Test/Idle, scan a DR and sample the strobes while in Update-DR
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout,
                         output logic oe_ok, output logic upd_req, output logic upd_rst,
                         output logic [DMI_BITS-1:0] upd_data);
    step(1); step(0); step(0);
    shift(n, din, 1'b1, dout, oe_ok);
    step(1);
    upd_req  = tap_req;
    upd_rst  = dmireset;
    upd_data = tap_data;
    step(0);
  endtask

  initial begin
    logic [63:0]         d;
    logic                ok, rq, rs;
    logic [DMI_BITS-1:0] td;
    int                  req0, rst0;

    trst_n   = 1'b0;
    tms      = 1'b1;
    tdi      = 1'b0;
    idcode   = 32'h1e200a6f;
    dtmcs    = 32'h00005071;
    dtm_data = {7'h04, 32'hdeadbeef, 2'b00};
    #25;
    check_vec("rst_tdo", {63'd0, tdo}, 64'd0);
    check_vec("rst_oe", {63'd0, tdo_oe}, 64'd0);
    check_vec("rst_req", {63'd0, tap_req}, 64'd0);
    check_vec("rst_dmireset", {63'd0, dmireset}, 64'd0);
    trst_n = 1'b1;
    step(1); step(1); step(1);
    step(0);

    // IDCODE straight after reset
    req0 = req_cnt;
    dr_scan(32, 64'd0, d, ok, rq, rs, td);
    check_vec("idcode_tdo", d, 64'h1e200a6f);
    check_vec("idcode_oe", {63'd0, ok}, 64'd1);
    check_vec("idcode_noreq", req_cnt - req0, 0);
    check_vec("idle_oe", {63'd0, tdo_oe}, 64'd0);

    // BYPASS via unknown code, IR capture pattern
    ir_scan(5'h0a, d);
    check_vec("ir_capture", d, 64'h01);
    dr_scan(8, 64'ha5, d, ok, rq, rs, td);
    check_vec("bypass_tdo", d, 64'h4a);
    check_vec("bypass_noreq", {63'd0, rq}, 64'd0);

    // Five TMS=1 from Shift-DR reach Test-Logic-Reset and restore IDCODE
    step(1); step(0); step(0);
    step(1); step(1); step(1); step(1); step(1);
    check_vec("tlr_req", {63'd0, tap_req}, 64'd0);
    check_vec("tlr_dmireset", {63'd0, dmireset}, 64'd0);
    step(0);
    dr_scan(32, 64'd0, d, ok, rq, rs, td);
    check_vec("tlr_idcode", d, 64'h1e200a6f);

    // DMI write with read-back of the response word
    ir_scan(5'h11, d);
    req0 = req_cnt;
    dr_scan(DMI_BITS, 64'h40_0000_0006, d, ok, rq, rs, td);
    check_vec("dmi_readback", d, 64'h13_7ab6_fbbc);
    check_vec("dmi_req", {63'd0, rq}, 64'd1);
    check_vec("dmi_data", {23'd0, td}, 64'h40_0000_0006);
    check_vec("dmi_req_once", req_cnt - req0, 1);
    check_vec("dmi_req_low", {63'd0, tap_req}, 64'd0);

    // Busy response reads op=2'b11
    dtm_data = {7'h00, 32'h00000000, 2'b11};
    dr_scan(DMI_BITS, 64'h0, d, ok, rq, rs, td);
    check_vec("dmi_busy_op", d[1:0], 64'd3);
    check_vec("dmi_req_twice", req_cnt - req0, 2);

    // DTMCS: dmireset only when bit 16 is written as 1
    ir_scan(5'h10, d);
    rst0 = rst_cnt;
    req0 = req_cnt;
    dr_scan(32, 64'h0001_0000, d, ok, rq, rs, td);
    check_vec("dtmcs_tdo", d, 64'h5071);
    check_vec("dtmcs_rst", {63'd0, rs}, 64'd1);
    check_vec("dtmcs_rst_once", rst_cnt - rst0, 1);
    dr_scan(32, 64'hfffe_ffff, d, ok, rq, rs, td);
    check_vec("dtmcs_norst", rst_cnt - rst0, 1);
    check_vec("dtmcs_noreq", req_cnt - req0, 0);

    // trst in the middle of a DMI shift aborts it
    ir_scan(5'h11, d);
    req0 = req_cnt;
    step(1); step(0); step(0);
    shift(10, 64'h3ff, 1'b0, d, ok);
    trst_n = 1'b0;
    #1;
    check_vec("abort_oe", {63'd0, tdo_oe}, 64'd0);
    check_vec("abort_req", {63'd0, tap_req}, 64'd0);
    @(posedge tck);
    #1;
    trst_n = 1'b1;
    step(1); step(1); step(1);
    check_vec("abort_noreq", req_cnt - req0, 0);
    step(0);
    dr_scan(32, 64'd0, d, ok, rq, rs, td);
    check_vec("abort_idcode", d, 64'h1e200a6f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
